// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores against a variable-latency
// data memory with a level req / pulsed ack handshake, stalling the pipeline
// until the access completes.
//
// Optional feature: define MEMCTL_TIMEOUT_EN to abort an access that sees no ack
// within TIMEOUT_CYCLES ACCESS cycles (sets sticky err_o, returns rdata_o = 0).
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   MemRead_i, MemWrite_i   load/store held in EX_MEM
//   addr_i, wdata_i         byte address and store data from EX_MEM
//   mem_req_o, mem_we_o     memory request (level until ack) and write enable
//   mem_addr_o, mem_wdata_o registered address / store data
//   mem_ack_i, mem_rdata_i  single-cycle completion pulse and read data
//   stall_o, bubble_o       freeze PC..EX_MEM / squash MEM_WB write-back
//   rdata_o                 load data to MEM_WB
//   err_o                   sticky timeout flag (0 when timeout is disabled)
//   stall_cnt_o             saturating count of stalled cycles
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_n;
    logic   start, ack, expire, timeout;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        ack     = 1'b0;
        expire  = 1'b0;
        stall_o = 1'b0;
        case (state)
            IDLE: begin
                start   = MemRead_i | MemWrite_i;
                // Reset also clears EX_MEM, so never hold the pipeline while in reset.
                stall_o = start & ~rst_i;
                state_n = start ? ACCESS : IDLE;
            end
            ACCESS: begin
                stall_o = 1'b1;
                ack     = mem_ack_i;
                // An ack in the expiry cycle wins over the timeout.
                expire  = timeout & ~mem_ack_i;
                state_n = (ack | expire) ? DONE : ACCESS;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bubble_o = stall_o;

`ifdef MEMCTL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // wait_cnt counts completed ACCESS cycles, so the last allowed one sees TIMEOUT_CYCLES-1.
    assign timeout = wait_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)                wait_cnt <= '0;
        else if (state != ACCESS) wait_cnt <= '0;
        else if (!mem_ack_i)      wait_cnt <= wait_cnt + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)       err_o <= 1'b0;
        else if (expire) err_o <= 1'b1;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            stall_cnt_o <= '0;
        end else begin
            // A simultaneous read+write is issued as a store.
            if (start) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
            end
            if (ack | expire) mem_req_o <= 1'b0;
            if (ack & ~mem_we_o) rdata_o <= mem_rdata_i;
            if (expire) rdata_o <= '0;
            if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl.
module tb_dmem_access_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i, mem_ack_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic        mem_req_o, mem_we_o, stall_o, bubble_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
    logic [31:0] stall_cnt_o;
    logic        s_req, s_we, s_stall, s_bubble, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_cnt;
    int          total = 0;
    int          bad = 0;
    int          req_rises = 0;
    logic        req_q = 1'b0;

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .bubble_o(bubble_o),
        .rdata_o(rdata_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(s_req), .mem_we_o(s_we),
        .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .stall_o(s_stall), .bubble_o(s_bubble),
        .rdata_o(s_rdata), .err_o(s_err), .stall_cnt_o(s_cnt)
    );

    always @(negedge clk_i) begin
        if (mem_req_o && !req_q) req_rises <= req_rises + 1;
        req_q <= mem_req_o;
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
        tick; tick;
        rst_i = 1'b0;
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cnt", stall_cnt_o, 0);
        chk("rst_stall", stall_o, 0);

        // Load 0x40, ack in third ACCESS cycle
        tick;
        MemRead_i = 1'b1; addr_i = 32'h40; #1;
        chk("ld_idle_stall", stall_o, 1);
        chk("ld_idle_bubble", bubble_o, 1);
        tick; #1;
        chk("ld_req", mem_req_o, 1);
        chk("ld_we", mem_we_o, 0);
        chk("ld_addr", mem_addr_o, 32'h40);
        tick; #1;
        chk("ld_wait_stall", stall_o, 1);
        tick;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
        chk("ld_ack_stall", stall_o, 1);
        tick;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
        chk("ld_done_stall", stall_o, 0);
        chk("ld_done_bubble", bubble_o, 0);
        chk("ld_rdata", rdata_o, 32'hCAFEF00D);
        chk("ld_done_req", mem_req_o, 0);
        chk("ld_cnt", stall_cnt_o, 4);
        chk("ld_sat_cnt", {29'd0, s_cnt}, 4);
        tick;
        MemRead_i = 1'b0; #1;
        chk("ld_idle_after", stall_o, 0);
        chk("ld_no_rereq", mem_req_o, 0);

        // Store 0x10 <- 0x12345678, ack in first ACCESS cycle
        MemWrite_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h12345678; #1;
        chk("st_idle_stall", stall_o, 1);
        tick;
        mem_ack_i = 1'b1; addr_i = 32'hFFFF; wdata_i = 32'h0; #1;
        chk("st_req", mem_req_o, 1);
        chk("st_we", mem_we_o, 1);
        chk("st_addr_held", mem_addr_o, 32'h10);
        chk("st_wdata_held", mem_wdata_o, 32'h12345678);
        chk("st_stall", stall_o, 1);
        tick;
        mem_ack_i = 1'b0; #1;
        chk("st_done_stall", stall_o, 0);
        chk("st_done_req", mem_req_o, 0);
        chk("st_rdata_kept", rdata_o, 32'hCAFEF00D);
        chk("st_cnt", stall_cnt_o, 6);
        tick;
        MemWrite_i = 1'b0; #1;

        // Two back-to-back loads, ack in first ACCESS cycle each
        req_rises = 0;
        MemRead_i = 1'b1; addr_i = 32'h80; #1;
        tick;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
        tick;
        mem_ack_i = 1'b0; #1;
        chk("b2b_a_rdata", rdata_o, 32'h11111111);
        chk("b2b_a_done_stall", stall_o, 0);
        tick;
        addr_i = 32'h84; #1;
        chk("b2b_b_idle_stall", stall_o, 1);
        tick;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222; #1;
        chk("b2b_b_addr", mem_addr_o, 32'h84);
        tick;
        mem_ack_i = 1'b0; #1;
        chk("b2b_b_rdata", rdata_o, 32'h22222222);
        tick;
        MemRead_i = 1'b0; #1;
        tick; tick;
        chk("b2b_req_pulses", req_rises, 2);
        chk("b2b_cnt", stall_cnt_o, 10);
        chk("sat_cnt", {29'd0, s_cnt}, 7);

        // Reset in the middle of an access, then a stray ack
        MemRead_i = 1'b1; addr_i = 32'h200; #1;
        tick; tick;
        rst_i = 1'b1; #1;
        chk("arst_req", mem_req_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_bubble", bubble_o, 0);
        chk("arst_addr", mem_addr_o, 0);
        chk("arst_rdata", rdata_o, 0);
        chk("arst_cnt", stall_cnt_o, 0);
        MemRead_i = 1'b0;
        tick;
        rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick;
        mem_ack_i = 1'b0; #1;
        chk("stray_req", mem_req_o, 0);
        chk("stray_rdata", rdata_o, 0);
        chk("stray_stall", stall_o, 0);
        chk("stray_cnt", stall_cnt_o, 0);

        // Long wait: ack on the fourth ACCESS cycle still completes normally
        MemRead_i = 1'b1; addr_i = 32'h300; #1;
        tick; tick; tick; tick;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A; #1;
        chk("late_stall", stall_o, 1);
        chk("late_req", mem_req_o, 1);
        tick;
        mem_ack_i = 1'b0; #1;
        chk("late_rdata", rdata_o, 32'h5A5A5A5A);
        chk("late_err", err_o, 0);
        chk("late_done_stall", stall_o, 0);
        tick;
        MemRead_i = 1'b0; #1;

`ifdef MEMCTL_TIMEOUT_EN
        // No ack: abort after four ACCESS cycles
        MemRead_i = 1'b1; addr_i = 32'h304; #1;
        tick; tick; tick; tick; #1;
        chk("to_c4_stall", stall_o, 1);
        chk("to_c4_err", err_o, 0);
        tick; #1;
        chk("to_err", err_o, 1);
        chk("to_rdata", rdata_o, 0);
        chk("to_stall", stall_o, 0);
        chk("to_req", mem_req_o, 0);
        tick;
        MemRead_i = 1'b0; #1;
        tick; tick;
        chk("to_err_sticky", err_o, 1);
`else
        // Without the timeout an access waits indefinitely
        MemRead_i = 1'b1; addr_i = 32'h304; #1;
        tick; tick; tick; tick; tick; tick; tick; #1;
        chk("wait_stall", stall_o, 1);
        chk("wait_req", mem_req_o, 1);
        chk("wait_err", err_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick;
        mem_ack_i = 1'b0; #1;
        chk("wait_rdata", rdata_o, 32'h0BADF00D);
        chk("wait_done_stall", stall_o, 0);
        tick;
        MemRead_i = 1'b0; #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the 5-stage pipeline when the data memory has variable latency.
It captures the load/store held in EX_MEM and drives a req/ack handshake to the memory.
While the access is outstanding it stalls PC, IF_ID, ID_EX and EX_MEM, and injects bubbles into MEM_WB.
It returns load data to MEM_WB's dataMem_data input in the cycle the pipeline is released.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack_i before abort (used only with optional feature)
CNT_W, 32, width of the stall-cycle statistics counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
MemRead_i  input  1  load in MEM stage (from EX_MEM)
MemWrite_i  input  1  store in MEM stage (from EX_MEM)
addr_i  input  32  ALU result = byte address
wdata_i  input  32  store data
mem_req_o  output  1  request to data memory, level, held until ack
mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o
mem_addr_o  output  32  registered address
mem_wdata_o  output  32  registered store data
mem_ack_i  input  1  memory completion, single-cycle pulse
mem_rdata_i  input  32  read data, valid with mem_ack_i
stall_o  output  1  freeze PC/IF_ID/ID_EX/EX_MEM
bubble_o  output  1  force MEM_WB RegWrite/MemtoReg to 0 this edge
rdata_o  output  32  load data to MEM_WB
err_o  output  1  sticky timeout flag
stall_cnt_o  output  CNT_W  total stalled cycles, saturating

Behaviour:
- Reset values: state IDLE; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0, stall_cnt_o=0.
- Reset is asynchronous and clears everything mid-access. mem_req_o drops in the same cycle; an outstanding ack after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, MemRead_i|MemWrite_i=1:
  - stall_o=1 combinationally.
  - Next edge registers addr_i, wdata_i and mem_we_o=MemWrite_i; mem_req_o=1; go to ACCESS.
- IDLE, no access: stall_o=0, stay IDLE.
- MemRead_i and MemWrite_i both 1: treated as a store; rdata_o unchanged.
- ACCESS:
  - stall_o=1, mem_req_o=1, address and data held stable.
  - On mem_ack_i: if read, rdata_o<=mem_rdata_i. mem_req_o<=0, go to DONE.
  - Ack in the first ACCESS cycle is legal, giving minimum total stall = 2 cycles.
- DONE:
  - Exactly one cycle, stall_o=0, so the pipeline advances and MEM_WB captures the instruction with rdata_o.
  - No new access starts in DONE; EX_MEM still holds the completed op during this cycle.
  - Unconditionally go to IDLE.
- bubble_o == stall_o. A stalled MEM instruction therefore reaches MEM_WB exactly once, at the DONE edge.
- Back-to-back loads: IDLE→ACCESS→DONE→IDLE→ACCESS…; each access costs ≥3 cycles.
- mem_ack_i outside ACCESS is ignored.
- rdata_o holds its last value between loads.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at all-ones.

Optional Feature:
MEMCTL_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mem_req_o<=0, rdata_o<=0, err_o<=1 (sticky until rst_i), go to DONE.
  - Ack arriving in the same cycle as expiry wins: normal completion, err_o unchanged.
- Undefined: no counter; ACCESS waits indefinitely; err_o tied 0.

Test Plan:
1. Load, addr=0x40, ack 3 cycles after req, rdata=0xCAFEF00D:
   - stall_o high 4 cycles, then DONE.
   - rdata_o=0xCAFEF00D, mem_we_o=0, bubble_o low only in DONE.
   - stall_cnt_o=4.
2. Store, addr=0x10, wdata=0x12345678, ack in first ACCESS cycle:
   - mem_we_o=1, addr/data held stable.
   - stall 2 cycles, rdata_o unchanged.
3. Two consecutive loads, acks after 1 cycle each:
   - exactly two mem_req_o pulses, DONE separates them, no duplicate request for the same op.
4. Reset asserted in ACCESS mid-wait:
   - mem_req_o, stall_o drop asynchronously; all outputs 0.
   - A later stray ack produces no state change.
5. MEMCTL_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
   - abort after 4 ACCESS cycles, err_o=1 and stays 1, rdata_o=0, pipeline released.
   - Repeat with ack on the 4th cycle: err_o=0.
6. CNT_W=3, 10 stalled cycles: stall_cnt_o saturates at 7.
